// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: radix-2^BITS_PER_CYCLE shift-add multiplier
// and restoring divider on operand magnitudes, with sign fix-up folded into the result load.
module mdu_iterative #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            MDU_start,
    input  logic [2:0]      MDU_op,
    input  logic [XLEN-1:0] MDU_rs1,
    input  logic [XLEN-1:0] MDU_rs2,
    input  logic            MDU_kill,
    input  logic            MDU_ack,
    output logic            MDU_ready,
    output logic            MDU_valid,
    output logic [XLEN-1:0] MDU_result
);

    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned BW = BITS_PER_CYCLE;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] opd, hi, lo;
    logic [XLEN-1:0] hi_n, lo_n, final_val;
    logic            last;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_val;

    logic [XLEN+BW-1:0] sum, ext;
    logic [XLEN:0]      trial, diff;
    logic [2*XLEN-1:0]  prod;

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        a_signed = (MDU_op == OP_MULH) || (MDU_op == OP_MULHSU) ||
                   (MDU_op == OP_DIV)  || (MDU_op == OP_REM);
        b_signed = (MDU_op == OP_MULH) || (MDU_op == OP_DIV) || (MDU_op == OP_REM);
        a_neg    = a_signed && MDU_rs1[XLEN-1];
        b_neg    = b_signed && MDU_rs2[XLEN-1];
        a_mag    = a_neg ? -MDU_rs1 : MDU_rs1;
        b_mag    = b_neg ? -MDU_rs2 : MDU_rs2;
        div_zero = MDU_op[2] && (MDU_rs2 == '0);
        div_ovf  = ((MDU_op == OP_DIV) || (MDU_op == OP_REM)) &&
                   (MDU_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (MDU_rs2 == '1);
        fast     = div_zero || div_ovf;
        fast_val = '0;
        if (div_zero)
            fast_val = MDU_op[1] ? MDU_rs1 : '1;
        else if (div_ovf)
            fast_val = MDU_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Multiply: {hi,lo} shifts right while lo's low bits select multiples of opd.
    // Divide: {hi,lo} shifts left, hi is the partial remainder, quotient bits enter lo.
    always_comb begin
        hi_n  = hi;
        lo_n  = lo;
        ext   = {{BW{1'b0}}, opd};
        sum   = '0;
        trial = '0;
        diff  = '0;
        if (!op_q[2]) begin
            sum = {{BW{1'b0}}, hi};
            for (int unsigned j = 0; j < BW; j++)
                if (lo[j])
                    sum = sum + (ext << j);
            hi_n = sum[XLEN+BW-1:BW];
            lo_n = {sum[BW-1:0], lo[XLEN-1:BW]};
        end else begin
            for (int unsigned j = 0; j < BW; j++) begin
                trial = {hi_n, lo_n[XLEN-1]};
                lo_n  = {lo_n[XLEN-2:0], 1'b0};
                diff  = trial - {1'b0, opd};
                if (!diff[XLEN]) begin
                    hi_n    = diff[XLEN-1:0];
                    lo_n[0] = 1'b1;
                end else begin
                    hi_n = trial[XLEN-1:0];
                end
            end
        end
    end

    always_comb begin
        prod = {hi_n, lo_n};
        if (neg_q)
            prod = -prod;
        final_val = '0;
        if (!op_q[2])
            final_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op_q[1])
            final_val = neg_r ? -hi_n : hi_n;
        else
            final_val = neg_q ? -lo_n : lo_n;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        MDU_ready = 1'b0;
        MDU_valid = 1'b0;
        case (state)
            IDLE: begin
                MDU_ready = 1'b1;
                if (MDU_start && !MDU_kill)
                    state_n = fast ? DONE : CALC;
            end
            CALC: begin
                if (MDU_kill)
                    state_n = IDLE;
                else if (last)
                    state_n = DONE;
            end
            DONE: begin
                MDU_valid = 1'b1;
                if (MDU_kill || MDU_ack)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            opd        <= '0;
            hi         <= '0;
            lo         <= '0;
            MDU_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MDU_start && !MDU_kill) begin
                        op_q  <= MDU_op;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        hi    <= '0;
                        if (MDU_op[2]) begin
                            opd <= b_mag;
                            lo  <= a_mag;
                        end else begin
                            opd <= a_mag;
                            lo  <= b_mag;
                        end
                        if (fast)
                            MDU_result <= fast_val;
                    end
                end
                CALC: begin
                    if (!MDU_kill) begin
                        hi  <= hi_n;
                        lo  <= lo_n;
                        cnt <= cnt + CW'(1);
                        if (last)
                            MDU_result <= final_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: radix-2 instance for most checks, radix-16 instance
// for the division repeat; sel4 steers start and output observation between them.
module tb_mdu_iterative;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        reset, start, kill, ack, sel4;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        ready1, valid1, ready4, valid4;
    logic [31:0] result1, result4;
    logic        ready, valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .SYS_clk(clk), .SYS_reset(reset), .MDU_start(start & ~sel4), .MDU_op(op),
        .MDU_rs1(rs1), .MDU_rs2(rs2), .MDU_kill(kill), .MDU_ack(ack),
        .MDU_ready(ready1), .MDU_valid(valid1), .MDU_result(result1)
    );

    mdu_iterative #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .SYS_clk(clk), .SYS_reset(reset), .MDU_start(start & sel4), .MDU_op(op),
        .MDU_rs1(rs1), .MDU_rs2(rs2), .MDU_kill(kill), .MDU_ack(ack),
        .MDU_ready(ready4), .MDU_valid(valid4), .MDU_result(result4)
    );

    assign ready  = sel4 ? ready4  : ready1;
    assign valid  = sel4 ? valid4  : valid1;
    assign result = sel4 ? result4 : result1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // lat = edges after the accept edge until valid is seen; N here means valid at accept+N+1.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; rs1 = ~a; rs2 = 32'h5A5A_0000;
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check({tag, " ack valid"}, {31'b0, valid}, 32'd0);
        check({tag, " ack ready"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [31:0] held;
        reset = 1'b1; start = 1'b0; kill = 1'b0; ack = 1'b0; sel4 = 1'b0;
        op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready1", {31'b0, ready1}, 32'd1);
        check("reset valid1", {31'b0, valid1}, 32'd0);
        check("reset result1", result1, 32'd0);
        check("reset ready4", {31'b0, ready4}, 32'd1);
        check("reset result4", result4, 32'd0);
        reset = 1'b0;

        // Reset at CALC cycle 10, then the same multiply runs to completion.
        op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid-reset busy", {31'b0, ready}, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-reset ready", {31'b0, ready}, 32'd1);
        check("mid-reset valid", {31'b0, valid}, 32'd0);
        check("mid-reset result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check("mid-reset no valid", {31'b0, seen}, 32'd0);
        run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32, 32'hFFFF_FFEB);
        do_ack("mul");

        run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000);
        do_ack("mulh");
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32, 32'hFFFF_FFFF);
        do_ack("mulhsu");

        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD);
        do_ack("div");
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF);
        do_ack("rem");
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32, 32'd14);
        do_ack("divu");
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32, 32'd2);
        do_ack("remu");

        run_op("divu0", OP_DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
        do_ack("divu0");
        run_op("rem0", OP_REM, 32'd5, 32'd0, 0, 32'd5);
        do_ack("rem0");
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        do_ack("div ovf");
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
        do_ack("rem ovf");

        // Backpressure in DONE, with a start pulse that must be masked.
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE);
        seen = 1'b1;
        held = result;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (!valid || result !== 32'hFFFF_FFFE) seen = 1'b0;
        end
        check("backpressure valid held", {31'b0, seen}, 32'd1);
        check("backpressure result held", held, 32'hFFFF_FFFE);
        check("backpressure result end", result, 32'hFFFF_FFFE);
        ack = 1'b1; start = 1'b1; op = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clk); #1;
        ack = 1'b0; start = 1'b0;
        check("ack+start ready", {31'b0, ready}, 32'd1);
        check("ack+start valid", {31'b0, valid}, 32'd0);
        run_op("after ack", OP_DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
        do_ack("after ack");

        // Start pulse with different operands during CALC must not disturb the op.
        op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int lat;
            lat = 3;
            while (!valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check("calc start latency", 32'(lat), 32'd32);
            check("calc start result", result, 32'd14);
        end
        do_ack("calc start");

        // Kill at CALC cycle 5.
        op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill ready", {31'b0, ready}, 32'd1);
        check("kill valid", {31'b0, valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check("kill no valid", {31'b0, seen}, 32'd0);

        start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1 = 32'd1; rs2 = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("idle kill ready", {31'b0, ready}, 32'd1);
        check("idle kill valid", {31'b0, valid}, 32'd0);

        run_op("kill+ack op", OP_REMU, 32'd5, 32'd0, 0, 32'd5);
        ack = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; kill = 1'b0;
        check("kill+ack ready", {31'b0, ready}, 32'd1);
        check("kill+ack valid", {31'b0, valid}, 32'd0);
        check("kill+ack result kept", result, 32'd5);

        // Radix-16 instance: same divisions, N = 8.
        sel4 = 1'b1;
        run_op("r4 div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 8, 32'hFFFF_FFFD);
        do_ack("r4 div");
        run_op("r4 rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 8, 32'hFFFF_FFFF);
        do_ack("r4 rem");
        run_op("r4 divu", OP_DIVU, 32'd100, 32'd7, 8, 32'd14);
        do_ack("r4 divu");
        run_op("r4 remu", OP_REMU, 32'd100, 32'd7, 8, 32'd2);
        do_ack("r4 remu");
        run_op("r4 mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 8, 32'h4000_0000);
        do_ack("r4 mulh");
        sel4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
